// File: rtl/rom_stream_reader.sv
// Streams one full burst of 2**ADDR_W words from a synchronous ROM into a valid/ready port.
// Optional ROM_CHECKSUM_EN adds a running checksum output of transferred beats.
module rom_stream_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   LAST_BEAT = {1'b0, LAST_ADDR};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINISH} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [RD_LAT-1:0]   vld_reg;
  logic [2:0]          inflight_reg;
  logic [2:0]          fifo_count_reg;
  logic [1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [DATA_W-1:0]   fifo_mem [0:3];
  logic [ADDR_W:0]     beat_cnt_reg;
  logic [3:0]          occupancy;
  logic                start_ok, issue, fifo_wr, fifo_rd, last_beat;

  // Reads are throttled so that buffered plus outstanding words never exceed the FIFO depth.
  assign occupancy = {1'b0, fifo_count_reg} + {1'b0, inflight_reg};
  assign start_ok  = (state_reg == S_IDLE) && start;
  assign issue     = (state_reg == S_FETCH) && (occupancy < 4'd4);
  assign fifo_wr   = vld_reg[RD_LAT-1];
  assign fifo_rd   = out_valid && out_ready;
  assign last_beat = fifo_rd && (beat_cnt_reg == LAST_BEAT);

  assign rom_addr  = addr_reg;
  assign out_valid = (fifo_count_reg != 3'd0);
  assign out_data  = fifo_mem[rd_ptr_reg];
  assign busy      = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
  assign done      = (state_reg == S_FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  if (issue && (addr_reg == LAST_ADDR)) state_next = S_DRAIN;
      S_DRAIN:  if (last_beat) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg     <= '0;
      beat_cnt_reg <= '0;
    end else if (start_ok) begin
      addr_reg     <= '0;
      beat_cnt_reg <= '0;
    end else begin
      if (issue && (addr_reg != LAST_ADDR)) addr_reg <= addr_reg + 1'b1;
      if (fifo_rd) beat_cnt_reg <= beat_cnt_reg + 1'b1;
    end
  end

  // Valid shift register aligns each issued read with its ROM data RD_LAT cycles later.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_vld
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_reg[gi] <= 1'b0;
        else if (gi == 0) vld_reg[gi] <= issue;
        else vld_reg[gi] <= vld_reg[(gi == 0) ? 0 : gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_reg   <= '0;
      fifo_count_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      inflight_reg   <= inflight_reg + 3'(issue) - 3'(fifo_wr);
      fifo_count_reg <= fifo_count_reg + 3'(fifo_wr) - 3'(fifo_rd);
      if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
      always_ff @(posedge clk or posedge reset) begin
        if (reset) fifo_mem[gi] <= '0;
        else if (fifo_wr && (wr_ptr_reg == 2'(gi))) fifo_mem[gi] <= rom_q;
      end
    end
  endgenerate

`ifdef ROM_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (fifo_rd)  checksum <= checksum + out_data;
  end
`endif

endmodule
